// File: rtl/bp_cac_lce_responder.sv
// CCE-side responder for an accelerator LCE: one transaction at a time (request -> memory -> LCE command -> optional ack).
// Optional feature macro: BP_CAC_RESP_TIMEOUT_EN adds a WAIT_ACK watchdog and a sticky timeout_o flag.
`default_nettype none

package bp_cac_pkg;
  typedef enum logic [1:0] {e_bp_inv_cfg = 2'd0, e_bp_default_cfg = 2'd1} bp_params_e;

  localparam int paddr_width_p  = 40;
  localparam int block_width_p  = 128;
  localparam int lce_id_width_p = 4;
  localparam int way_id_width_p = 3;

  typedef enum logic [2:0] {
    e_lce_req_rd_miss = 3'd0,
    e_lce_req_wr_miss = 3'd1,
    e_lce_req_uc_rd   = 3'd2,
    e_lce_req_uc_wr   = 3'd3
  } bp_lce_cce_req_type_e;

  typedef enum logic [3:0] {
    e_lce_cmd_sync        = 4'd0,
    e_lce_cmd_set_clear   = 4'd1,
    e_lce_cmd_invalidate  = 4'd2,
    e_lce_cmd_uc_st_done  = 4'd3,
    e_lce_cmd_data        = 4'd4,
    e_lce_cmd_uc_data     = 4'd5
  } bp_lce_cmd_type_e;

  typedef enum logic [2:0] {
    e_lce_cce_sync_ack    = 3'd0,
    e_lce_cce_inv_ack     = 3'd1,
    e_lce_cce_coh_ack     = 3'd2,
    e_lce_cce_resp_wb     = 3'd3,
    e_lce_cce_resp_null_wb = 3'd4
  } bp_lce_cce_resp_type_e;

  typedef enum logic [2:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_M = 3'd3
  } bp_coh_states_e;

  typedef enum logic [2:0] {
    e_cce_mem_rd    = 3'd0,
    e_cce_mem_wr    = 3'd1,
    e_cce_mem_uc_rd = 3'd2,
    e_cce_mem_uc_wr = 3'd3
  } bp_cce_mem_cmd_type_e;

  typedef struct packed {
    bp_lce_cce_req_type_e        msg_type;
    logic [paddr_width_p-1:0]    addr;
    logic [lce_id_width_p-1:0]   lce_id;
    logic [way_id_width_p-1:0]   way_id;
    logic [2:0]                  size;
    logic [block_width_p-1:0]    data;
  } bp_lce_cce_req_s;

  typedef struct packed {
    bp_lce_cmd_type_e            msg_type;
    logic [lce_id_width_p-1:0]   dst_id;
    logic [paddr_width_p-1:0]    addr;
    logic [way_id_width_p-1:0]   way_id;
    bp_coh_states_e              state;
    logic [block_width_p-1:0]    data;
  } bp_lce_cmd_s;

  typedef struct packed {
    bp_lce_cce_resp_type_e       msg_type;
    logic [paddr_width_p-1:0]    addr;
    logic [lce_id_width_p-1:0]   src_id;
  } bp_lce_cce_resp_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e        msg_type;
    logic [paddr_width_p-1:0]    addr;
    logic [2:0]                  size;
    logic [block_width_p-1:0]    data;
  } bp_cce_mem_msg_s;
endpackage

module bp_cac_lce_responder
  import bp_cac_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_inv_cfg,
  parameter int         ack_timeout_p = 1024
) (
  input  logic             clk_i,
  input  logic             reset_n_i,

  input  bp_lce_cce_req_s  lce_req_i,
  input  logic             lce_req_v_i,
  output logic             lce_req_yumi_o,

  output bp_lce_cmd_s      lce_cmd_o,
  output logic             lce_cmd_v_o,
  input  logic             lce_cmd_ready_i,

  input  bp_lce_cce_resp_s lce_resp_i,
  input  logic             lce_resp_v_i,
  output logic             lce_resp_yumi_o,

  output bp_cce_mem_msg_s  mem_cmd_o,
  output logic             mem_cmd_v_o,
  input  logic             mem_cmd_ready_i,

  input  bp_cce_mem_msg_s  mem_resp_i,
  input  logic             mem_resp_v_i,
  output logic             mem_resp_yumi_o,

  output logic             busy_o,
  output logic             timeout_o
);

  if (bp_params_p != e_bp_inv_cfg) begin : g_cfg_check
    $error("bp_cac_lce_responder: only e_bp_inv_cfg message widths are provided");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_CMD  = 3'd1,
    S_MEM_RESP = 3'd2,
    S_LCE_CMD  = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  bp_lce_cce_req_s          req_q, req_d;
  logic [block_width_p-1:0] data_q, data_d;
  logic                     is_coh_w;
  logic                     ack_w;
  logic                     expire_w;
  logic                     unused_w;

  assign is_coh_w = (req_q.msg_type == e_lce_req_rd_miss) || (req_q.msg_type == e_lce_req_wr_miss);
  assign ack_w    = lce_resp_v_i && (lce_resp_i.msg_type == e_lce_cce_coh_ack)
                    && (lce_resp_i.addr == req_q.addr);
  assign busy_o   = (state_q != S_IDLE);
  assign unused_w = ^{lce_resp_i.src_id, mem_resp_i.msg_type, mem_resp_i.addr, mem_resp_i.size};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Payload registers carry no reset: their contents only matter outside IDLE.
  always_ff @(posedge clk_i) begin
    req_q  <= req_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    data_d          = data_q;
    lce_req_yumi_o  = 1'b0;
    mem_cmd_v_o     = 1'b0;
    mem_resp_yumi_o = 1'b0;
    lce_cmd_v_o     = 1'b0;
    lce_resp_yumi_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        lce_req_yumi_o = lce_req_v_i & reset_n_i;
        if (lce_req_v_i && reset_n_i) begin
          req_d   = lce_req_i;
          state_d = S_MEM_CMD;
        end
      end
      S_MEM_CMD: begin
        mem_cmd_v_o = 1'b1;
        if (mem_cmd_ready_i) state_d = S_MEM_RESP;
      end
      S_MEM_RESP: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) begin
          data_d  = mem_resp_i.data;
          state_d = S_LCE_CMD;
        end
      end
      S_LCE_CMD: begin
        lce_cmd_v_o = 1'b1;
        if (lce_cmd_ready_i) state_d = is_coh_w ? S_WAIT_ACK : S_IDLE;
      end
      S_WAIT_ACK: begin
        // Non-matching responses are consumed and dropped.
        lce_resp_yumi_o = lce_resp_v_i;
        if (ack_w || expire_w) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_cmd_o      = '0;
    mem_cmd_o.addr = req_q.addr;
    mem_cmd_o.size = req_q.size;
    case (req_q.msg_type)
      e_lce_req_uc_rd: mem_cmd_o.msg_type = e_cce_mem_uc_rd;
      e_lce_req_uc_wr: begin
        mem_cmd_o.msg_type = e_cce_mem_uc_wr;
        mem_cmd_o.data     = req_q.data;
      end
      default:         mem_cmd_o.msg_type = e_cce_mem_rd;
    endcase

    lce_cmd_o        = '0;
    lce_cmd_o.dst_id = req_q.lce_id;
    lce_cmd_o.addr   = req_q.addr;
    case (req_q.msg_type)
      e_lce_req_uc_rd: begin
        lce_cmd_o.msg_type = e_lce_cmd_uc_data;
        lce_cmd_o.data     = data_q;
      end
      e_lce_req_uc_wr: lce_cmd_o.msg_type = e_lce_cmd_uc_st_done;
      default: begin
        lce_cmd_o.msg_type = e_lce_cmd_data;
        lce_cmd_o.way_id   = req_q.way_id;
        lce_cmd_o.state    = (req_q.msg_type == e_lce_req_wr_miss) ? e_COH_M : e_COH_E;
        lce_cmd_o.data     = data_q;
      end
    endcase
  end

`ifdef BP_CAC_RESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(ack_timeout_p + 1);

  logic [CNT_W-1:0] ack_cnt_q;
  logic             timeout_q;

  assign expire_w  = (state_q == S_WAIT_ACK) && !ack_w
                     && (ack_cnt_q == CNT_W'(ack_timeout_p - 1));
  assign timeout_o = timeout_q;

  // Counter idles at zero so it is already cleared on WAIT_ACK entry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ack_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      ack_cnt_q <= (state_q == S_WAIT_ACK) ? ack_cnt_q + CNT_W'(1) : '0;
      if (expire_w) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_w;

  assign expire_w         = 1'b0;
  assign timeout_o        = 1'b0;
  assign unused_timeout_w = ack_timeout_p[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_cac_lce_responder.sv
// Self-checking bench for bp_cac_lce_responder: directed scenarios plus randomized transactions vs. a reference model.
module tb_bp_cac_lce_responder;
  import bp_cac_pkg::*;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b0;
  bp_lce_cce_req_s  lce_req_i;
  logic             lce_req_v_i;
  logic             lce_req_yumi_o;
  bp_lce_cmd_s      lce_cmd_o;
  logic             lce_cmd_v_o;
  logic             lce_cmd_ready_i;
  bp_lce_cce_resp_s lce_resp_i;
  logic             lce_resp_v_i;
  logic             lce_resp_yumi_o;
  bp_cce_mem_msg_s  mem_cmd_o;
  logic             mem_cmd_v_o;
  logic             mem_cmd_ready_i;
  bp_cce_mem_msg_s  mem_resp_i;
  logic             mem_resp_v_i;
  logic             mem_resp_yumi_o;
  logic             busy_o;
  logic             timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  bp_cac_lce_responder #(.bp_params_p(e_bp_inv_cfg), .ack_timeout_p(16)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_yumi_o(lce_req_yumi_o),
    .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_ready_i(lce_cmd_ready_i),
    .lce_resp_i(lce_resp_i), .lce_resp_v_i(lce_resp_v_i), .lce_resp_yumi_o(lce_resp_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: what the memory and the LCE must see for a given request.
  function automatic bp_cce_mem_msg_s model_mem_cmd(bp_lce_cce_req_s r);
    bp_cce_mem_msg_s m;
    m = '0;
    m.addr = r.addr;
    m.size = r.size;
    if (r.msg_type == e_lce_req_uc_rd)      m.msg_type = e_cce_mem_uc_rd;
    else if (r.msg_type == e_lce_req_uc_wr) begin m.msg_type = e_cce_mem_uc_wr; m.data = r.data; end
    else                                    m.msg_type = e_cce_mem_rd;
    return m;
  endfunction

  function automatic bp_lce_cmd_s model_lce_cmd(bp_lce_cce_req_s r, logic [127:0] md);
    bp_lce_cmd_s c;
    c = '0;
    c.dst_id = r.lce_id;
    if (r.msg_type == e_lce_req_uc_rd)      begin c.msg_type = e_lce_cmd_uc_data; c.data = md; end
    else if (r.msg_type == e_lce_req_uc_wr) c.msg_type = e_lce_cmd_uc_st_done;
    else begin
      c.msg_type = e_lce_cmd_data;
      c.way_id   = r.way_id;
      c.state    = (r.msg_type == e_lce_req_wr_miss) ? e_COH_M : e_COH_E;
      c.data     = md;
    end
    return c;
  endfunction

  function automatic bit is_coh(bp_lce_cce_req_s r);
    return (r.msg_type == e_lce_req_rd_miss) || (r.msg_type == e_lce_req_wr_miss);
  endfunction

  function automatic bp_lce_cce_req_s mk_req(bp_lce_cce_req_type_e t, logic [39:0] a,
                                             logic [3:0] id, logic [2:0] way, logic [127:0] d);
    bp_lce_cce_req_s r;
    r = '0;
    r.msg_type = t; r.addr = a; r.lce_id = id; r.way_id = way; r.size = 3'd3; r.data = d;
    return r;
  endfunction

  task automatic accept(input bp_lce_cce_req_s r, output bit yumi);
    lce_req_i = r;
    lce_req_v_i = 1'b1;
    #1;
    yumi = lce_req_yumi_o;
    step();
    lce_req_v_i = 1'b0;
  endtask

  // Drives the memory and LCE-command handshakes; returns observations only.
  task automatic complete(input logic [127:0] md, input int mem_stall, input int cmd_stall,
                          output bp_cce_mem_msg_s mc, output bp_lce_cmd_s lc, output int cycles,
                          output int cmd_vcyc, output bit stable, output bit ok, output bit rsp_yumi);
    bit done;
    cycles = 0; cmd_vcyc = 0; stable = 1'b1; ok = 1'b1; rsp_yumi = 1'b0; mc = '0; lc = '0;
    lce_resp_i = '0;
    lce_resp_v_i = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      rsp_yumi |= lce_resp_yumi_o;
      if (mem_cmd_v_o && c >= mem_stall) begin mc = mem_cmd_o; mem_cmd_ready_i = 1'b1; done = 1'b1; end
      step(); cycles++; mem_cmd_ready_i = 1'b0;
      if (done) break;
    end
    ok &= done;
    mem_resp_i = '0; mem_resp_i.data = md; mem_resp_v_i = 1'b1; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      rsp_yumi |= lce_resp_yumi_o;
      done = mem_resp_yumi_o;
      step(); cycles++;
      if (done) break;
    end
    mem_resp_v_i = 1'b0;
    ok &= done;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      rsp_yumi |= lce_resp_yumi_o;
      if (lce_cmd_v_o) begin
        if (cmd_vcyc == 0) lc = lce_cmd_o;
        else if (lce_cmd_o !== lc) stable = 1'b0;
        cmd_vcyc++;
        if (cmd_vcyc > cmd_stall) begin lce_cmd_ready_i = 1'b1; done = 1'b1; end
      end
      step(); cycles++; lce_cmd_ready_i = 1'b0;
      if (done) break;
    end
    lce_resp_v_i = 1'b0;
    ok &= done;
  endtask

  task automatic send_resp(input bp_lce_cce_resp_type_e t, input logic [39:0] a, output bit yumi);
    lce_resp_i = '0; lce_resp_i.msg_type = t; lce_resp_i.addr = a; lce_resp_v_i = 1'b1;
    #1;
    yumi = lce_resp_yumi_o;
    step();
    lce_resp_v_i = 1'b0;
  endtask

  task automatic test_reset();
    lce_req_i = '0; lce_resp_i = '0; mem_resp_i = '0;
    lce_req_v_i = 1'b1; lce_resp_v_i = 1'b1; mem_resp_v_i = 1'b1;
    lce_cmd_ready_i = 1'b1; mem_cmd_ready_i = 1'b1;
    reset_n_i = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({lce_req_yumi_o, lce_cmd_v_o, lce_resp_yumi_o, mem_cmd_v_o, mem_resp_yumi_o, busy_o, timeout_o} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {lce_req_yumi_o, lce_cmd_v_o, lce_resp_yumi_o, mem_cmd_v_o, mem_resp_yumi_o, busy_o, timeout_o});
    else n_pass++;
    lce_req_v_i = 1'b0; lce_resp_v_i = 1'b0; mem_resp_v_i = 1'b0;
    lce_cmd_ready_i = 1'b0; mem_cmd_ready_i = 1'b0;
    reset_n_i = 1'b1;
    step();
    n_checks++;
    if ({busy_o, timeout_o, mem_cmd_v_o, lce_cmd_v_o} !== 4'b0)
      $display("FAIL reset_release_idle: got %b want 0000", {busy_o, timeout_o, mem_cmd_v_o, lce_cmd_v_o});
    else n_pass++;
  endtask

  task automatic test_uc_read();
    bp_lce_cce_req_s r; bp_cce_mem_msg_s mc; bp_lce_cmd_s lc;
    int cyc, vc; bit st, ok, ry, y;
    r = mk_req(e_lce_req_uc_rd, 40'h80_0000_1000, 4'd1, 3'd0, '0);
    accept(r, y);
    complete(128'hDEADBEEF, 0, 0, mc, lc, cyc, vc, st, ok, ry);
    n_checks++;
    if (mc.msg_type !== e_cce_mem_uc_rd || mc.addr !== 40'h80_0000_1000)
      $display("FAIL ucrd_mem_cmd: got type %0d addr %h want type %0d addr 8000001000", mc.msg_type, mc.addr, e_cce_mem_uc_rd);
    else n_pass++;
    n_checks++;
    if (lc.msg_type !== e_lce_cmd_uc_data || lc.data !== 128'hDEADBEEF)
      $display("FAIL ucrd_lce_cmd: got type %0d data %h want type %0d data deadbeef", lc.msg_type, lc.data, e_lce_cmd_uc_data);
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0 || !ok || !y) $display("FAIL ucrd_done: busy %b ok %b yumi %b want 0 1 1", busy_o, ok, y);
    else n_pass++;
    n_checks++;
    if (cyc + 1 !== 4) $display("FAIL ucrd_latency: got %0d want 4", cyc + 1);
    else n_pass++;
  endtask

  task automatic test_coh_stall();
    bp_lce_cce_req_s r; bp_cce_mem_msg_s mc; bp_lce_cmd_s lc; logic [127:0] md;
    int cyc, vc, held; bit st, ok, ry, y;
    md = {$urandom, $urandom, $urandom, $urandom};
    r = mk_req(e_lce_req_rd_miss, 40'h80_0000_0040, 4'd3, 3'd2, '0);
    accept(r, y);
    complete(md, 0, 3, mc, lc, cyc, vc, st, ok, ry);
    n_checks++;
    if (vc !== 4 || !st) $display("FAIL coh_stall_stable: valid cycles %0d stable %b want 4 1", vc, st);
    else n_pass++;
    n_checks++;
    if (lc.msg_type !== e_lce_cmd_data || lc.way_id !== 3'd2 || lc.state !== e_COH_E || lc.data !== md || lc.dst_id !== 4'd3)
      $display("FAIL coh_stall_cmd: got type %0d way %0d state %0d dst %0d", lc.msg_type, lc.way_id, lc.state, lc.dst_id);
    else n_pass++;
    held = 0;
    for (int i = 0; i < 3; i++) begin step(); if (busy_o) held++; end
    n_checks++;
    if (held !== 3) $display("FAIL coh_wait_hold: busy cycles %0d want 3", held);
    else n_pass++;
    send_resp(e_lce_cce_coh_ack, 40'h80_0000_0040, y);
    n_checks++;
    if (!y || busy_o !== 1'b0) $display("FAIL coh_ack_done: yumi %b busy %b want 1 0", y, busy_o);
    else n_pass++;
  endtask

  task automatic test_wrong_ack();
    bp_lce_cce_req_s r; bp_cce_mem_msg_s mc; bp_lce_cmd_s lc;
    int cyc, vc; bit st, ok, ry, y;
    r = mk_req(e_lce_req_wr_miss, 40'h80_0000_0040, 4'd2, 3'd5, '0);
    accept(r, y);
    complete(128'h5, 0, 0, mc, lc, cyc, vc, st, ok, ry);
    n_checks++;
    if (lc.state !== e_COH_M || mc.msg_type !== e_cce_mem_rd)
      $display("FAIL wrmiss_state: got state %0d memtype %0d want %0d %0d", lc.state, mc.msg_type, e_COH_M, e_cce_mem_rd);
    else n_pass++;
    send_resp(e_lce_cce_coh_ack, 40'h80_0000_0080, y);
    n_checks++;
    if (!y || busy_o !== 1'b1) $display("FAIL wrong_ack_dropped: yumi %b busy %b want 1 1", y, busy_o);
    else n_pass++;
    send_resp(e_lce_cce_coh_ack, 40'h80_0000_0040, y);
    n_checks++;
    if (!y || busy_o !== 1'b0) $display("FAIL right_ack_done: yumi %b busy %b want 1 0", y, busy_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bp_lce_cce_req_s r; bp_cce_mem_msg_s mc; bp_lce_cmd_s lc;
    int cyc, vc; bit st, ok, ry, y;
    r = mk_req(e_lce_req_uc_rd, 40'h80_0000_2000, 4'd1, 3'd0, '0);
    accept(r, y);
    #1; mem_cmd_ready_i = 1'b1;
    step(); mem_cmd_ready_i = 1'b0;
    mem_resp_v_i = 1'b1; lce_req_v_i = 1'b1; lce_resp_v_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1;
    n_checks++;
    if ({lce_req_yumi_o, lce_cmd_v_o, lce_resp_yumi_o, mem_cmd_v_o, mem_resp_yumi_o, busy_o, timeout_o} !== 7'b0)
      $display("FAIL reset_mid_outputs: got %b want 0000000",
               {lce_req_yumi_o, lce_cmd_v_o, lce_resp_yumi_o, mem_cmd_v_o, mem_resp_yumi_o, busy_o, timeout_o});
    else n_pass++;
    mem_resp_v_i = 1'b0; lce_req_v_i = 1'b0; lce_resp_v_i = 1'b0;
    step(); step();
    reset_n_i = 1'b1;
    step();
    r = mk_req(e_lce_req_uc_wr, 40'h80_0000_3000, 4'd6, 3'd0, 128'hABCD);
    accept(r, y);
    complete('0, 1, 1, mc, lc, cyc, vc, st, ok, ry);
    n_checks++;
    if (!y || !ok || lc.msg_type !== e_lce_cmd_uc_st_done || lc.dst_id !== 4'd6 || mc.data !== 128'hABCD || busy_o !== 1'b0)
      $display("FAIL reset_mid_recover: yumi %b ok %b type %0d dst %0d data %h busy %b", y, ok, lc.msg_type, lc.dst_id, mc.data, busy_o);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bp_lce_cce_req_s r; bp_cce_mem_msg_s mc; bp_lce_cmd_s lc;
    int cyc, vc, cnt; bit st, ok, ry, y;
    r = mk_req(e_lce_req_rd_miss, 40'h80_0000_0100, 4'd0, 3'd1, '0);
    accept(r, y);
    complete('1, 0, 0, mc, lc, cyc, vc, st, ok, ry);
    cnt = 0;
`ifdef BP_CAC_RESP_TIMEOUT_EN
    while (busy_o && cnt < 200) begin step(); cnt++; end
    n_checks++;
    if (cnt !== 16 || timeout_o !== 1'b1) $display("FAIL timeout_expire: cycles %0d timeout %b want 16 1", cnt, timeout_o);
    else n_pass++;
`else
    for (int i = 0; i < 100; i++) begin step(); if (busy_o) cnt++; end
    n_checks++;
    if (cnt !== 100 || timeout_o !== 1'b0) $display("FAIL no_timeout_wait: busy cycles %0d timeout %b want 100 0", cnt, timeout_o);
    else n_pass++;
`endif
    #2 reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    step();
    n_checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL timeout_cleared: timeout %b busy %b want 0 0", timeout_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bp_lce_cce_req_s r1, r2; bp_cce_mem_msg_s mc; bp_lce_cmd_s lc;
    int cyc, vc, early; bit st, ok, ry, y;
    r1 = mk_req(e_lce_req_uc_wr, 40'h80_0000_4000, 4'd4, 3'd0, 128'h1234);
    r2 = mk_req(e_lce_req_uc_rd, 40'h80_0000_5000, 4'd5, 3'd0, '0);
    lce_req_i = r1; lce_req_v_i = 1'b1;
    #1; y = lce_req_yumi_o;
    step();
    lce_req_i = r2;
    early = 0;
    #1; early += int'(lce_req_yumi_o); mc = mem_cmd_o; mem_cmd_ready_i = 1'b1;
    step(); mem_cmd_ready_i = 1'b0; mem_resp_v_i = 1'b1; mem_resp_i = '0;
    #1; early += int'(lce_req_yumi_o);
    step(); mem_resp_v_i = 1'b0;
    #1; early += int'(lce_req_yumi_o); lc = lce_cmd_o; lce_cmd_ready_i = 1'b1;
    step(); lce_cmd_ready_i = 1'b0;
    n_checks++;
    if (mc.msg_type !== e_cce_mem_uc_wr || mc.data !== 128'h1234 || lc.msg_type !== e_lce_cmd_uc_st_done)
      $display("FAIL b2b_ucwr: memtype %0d data %h cmdtype %0d", mc.msg_type, mc.data, lc.msg_type);
    else n_pass++;
    n_checks++;
    if (!y || early !== 0) $display("FAIL b2b_no_early_accept: first yumi %b early accepts %0d want 1 0", y, early);
    else n_pass++;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || lce_req_yumi_o !== 1'b1) $display("FAIL b2b_accept_in_idle: busy %b yumi %b want 0 1", busy_o, lce_req_yumi_o);
    else n_pass++;
    step(); lce_req_v_i = 1'b0;
    complete(128'h77, 0, 0, mc, lc, cyc, vc, st, ok, ry);
    n_checks++;
    if (!ok || mc.addr !== 40'h80_0000_5000 || lc.msg_type !== e_lce_cmd_uc_data || lc.data !== 128'h77)
      $display("FAIL b2b_second: ok %b addr %h type %0d data %h", ok, mc.addr, lc.msg_type, lc.data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      bp_lce_cce_req_s r; bp_cce_mem_msg_s mc, emc; bp_lce_cmd_s lc, elc; logic [127:0] md;
      int ms, cs, cyc, vc, nj, bad; bit st, ok, ry, y;
      r = mk_req(bp_lce_cce_req_type_e'($urandom_range(0, 3)), {8'h80, $urandom},
                 4'($urandom), 3'($urandom), {$urandom, $urandom, $urandom, $urandom});
      r.size = 3'($urandom);
      md = {$urandom, $urandom, $urandom, $urandom};
      ms = $urandom_range(0, 3); cs = $urandom_range(0, 3);
      emc = model_mem_cmd(r); elc = model_lce_cmd(r, md);
      accept(r, y);
      complete(md, ms, cs, mc, lc, cyc, vc, st, ok, ry);
      n_checks++;
      if (!y || !ok || ry || !st || vc !== cs + 1 || cyc !== ms + cs + 3)
        $display("FAIL rnd%0d_handshake: yumi %b ok %b respyumi %b stable %b vcyc %0d cyc %0d", t, y, ok, ry, st, vc, cyc);
      else n_pass++;
      n_checks++;
      if (mc.msg_type !== emc.msg_type || mc.addr !== emc.addr || mc.size !== emc.size ||
          (r.msg_type == e_lce_req_uc_wr && mc.data !== emc.data))
        $display("FAIL rnd%0d_mem_cmd: got type %0d addr %h size %0d want type %0d addr %h size %0d",
                 t, mc.msg_type, mc.addr, mc.size, emc.msg_type, emc.addr, emc.size);
      else n_pass++;
      n_checks++;
      if (lc.msg_type !== elc.msg_type || lc.dst_id !== elc.dst_id ||
          (elc.msg_type != e_lce_cmd_uc_st_done && lc.data !== elc.data) ||
          (is_coh(r) && (lc.way_id !== elc.way_id || lc.state !== elc.state)))
        $display("FAIL rnd%0d_lce_cmd: got type %0d dst %0d way %0d state %0d want type %0d dst %0d way %0d state %0d",
                 t, lc.msg_type, lc.dst_id, lc.way_id, lc.state, elc.msg_type, elc.dst_id, elc.way_id, elc.state);
      else n_pass++;
      if (is_coh(r)) begin
        nj = $urandom_range(0, 2); bad = 0;
        for (int j = 0; j < nj; j++) begin
          if (j == 0) send_resp(e_lce_cce_coh_ack, r.addr ^ 40'h40, y);
          else        send_resp(e_lce_cce_inv_ack, r.addr, y);
          if (!y || !busy_o) bad++;
        end
        send_resp(e_lce_cce_coh_ack, r.addr, y);
        n_checks++;
        if (bad !== 0 || !y || busy_o !== 1'b0)
          $display("FAIL rnd%0d_ack: junk errors %0d yumi %b busy %b want 0 1 0", t, bad, y, busy_o);
        else n_pass++;
      end else begin
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL rnd%0d_uc_idle: busy %b want 0", t, busy_o);
        else n_pass++;
      end
    end
  endtask

  initial begin
    lce_req_i = '0; lce_resp_i = '0; mem_resp_i = '0;
    lce_req_v_i = 1'b0; lce_resp_v_i = 1'b0; mem_resp_v_i = 1'b0;
    lce_cmd_ready_i = 1'b0; mem_cmd_ready_i = 1'b0;
    test_reset();
    test_uc_read();
    test_coh_stall();
    test_wrong_ack();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
